vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the soda vending datapath. Takes the nickel/dime/quarter coin strobes, maintains the credit, and handshakes a vend request to the dispenser. It then pays out change one coin at a time through a return-coin handshake, and services a cancel/refund button. It is the block that owns the credit register and decides when the dispenser and the coin-return mechanism fire.

## Interface
Parameters:
- PRICE, 4, soda price in nickel units (4 = 20 cents); legal range 1..31
- CREDIT_W, 5, credit register width in nickel units; max credit 2^CREDIT_W-1 = 31

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- nickel  in  1  coin strobe, value 1 unit
- dime  in  1  coin strobe, value 2 units
- quarter  in  1  coin strobe, value 5 units
- cancel  in  1  refund request, sampled each cycle
- vend_ack  in  1  dispenser accepted vend
- change_ack  in  1  coin-return mechanism released the presented coin
- credit  out  CREDIT_W  current credit in nickel units
- vend_req  out  1  request dispenser to release one soda
- ret_nickel  out  1  present one nickel for return
- ret_dime  out  1  present one dime for return
- coin_reject  out  1  one-cycle pulse: the coin presented last cycle was rejected
- state_check  out  3  current FSM state encoding, for debug

## Operation
- States and encodings: COLLECT=3'b000, VEND=3'b001, CHANGE=3'b010, REFUND=3'b011. Other encodings are unreachable and recover to COLLECT with credit cleared.
- Coin decode:
  - exactly one strobe high = legal coin
  - more than one high = illegal, rejected
  - all low = no coin
- COLLECT:
  - cancel has priority. If cancel=1 and credit>0, go to REFUND; a coin presented in the same cycle is rejected.
  - If cancel=1 and credit=0, the cancel is ignored and any coin is processed normally.
  - A legal coin with credit+value<=31 is accepted: credit <= credit+value.
  - A legal coin with credit+value>31 is rejected and credit is unchanged.
  - If the post-update credit is >=PRICE, go to VEND.
- VEND:
  - vend_req=1 until vend_ack is sampled high.
  - On that edge, credit <= credit-PRICE. Next state is COLLECT if the result is 0, else CHANGE.
  - cancel is ignored.
- CHANGE and REFUND share the same payout:
  - If credit>=2, present ret_dime; if credit=1, present ret_nickel. Exactly one ret_* is high.
  - The presented coin is held stable until change_ack is sampled high.
  - On ack, credit decrements by 2 or 1. When credit reaches 0, go to COLLECT.
- In VEND/CHANGE/REFUND every coin, legal or not, is rejected.
- vend_ack outside VEND and change_ack outside CHANGE/REFUND are ignored.
- Arithmetic is performed at CREDIT_W+1 bits for the overflow check. Credit never wraps and never goes negative.

## Timing
- Reset values: credit=0, state_check=3'b000, and vend_req, ret_nickel, ret_dime, coin_reject all 0.
- Reset mid-operation abandons any pending vend or payout. Credit is lost; no coins are returned.
- All outputs are registered. vend_req, ret_* and state_check are Moore outputs of the state/credit registers.
- Coin accepted at edge N: credit is visible in cycle N+1. If it reaches PRICE, vend_req=1 in cycle N+1.
- coin_reject is high exactly in the cycle after the rejected strobe, for one cycle.
- Handshake latency: vend_ack high in the first vend_req cycle completes the handshake at that edge, so the minimum VEND dwell is 1 cycle. The same rule applies to change_ack and ret_*.
- Best case from quarter at credit 0 with PRICE=4 and acks tied high: 3 cycles back to COLLECT (VEND, CHANGE nickel, COLLECT).

## Structure
- Package vend_pkg holds:
  - the state enum with the encodings above
  - coin value constants (NICKEL_V=1, DIME_V=2, QUARTER_V=5)
  - the default PRICE and CREDIT_W
- Sub-module coin_decoder: combinational. Inputs nickel/dime/quarter; outputs valid, illegal, and a 3-bit value. Instantiated once.
- FSM, credit register and output registers live in vend_controller.

## Test plan
- Reset: hold rst=1 for 2 cycles with coins toggling -> credit=0, state_check=000, all strobes 0.
- Exact price: PRICE=4, dime, dime, vend_ack tied high -> credit 2, then 4, vend_req one cycle, credit 0, back to COLLECT, no ret_*.
- Overpay with change: quarter with acks delayed 3 cycles each -> credit 5, then vend_req held 3 cycles, credit 1, ret_nickel held 3 cycles, then credit 0.
- Refund: nickel, dime, then cancel -> credit 3, REFUND; ret_dime then ret_nickel; credit 0, COLLECT, no vend_req ever.
- Rejects: nickel+dime together -> coin_reject pulse, credit 0. Quarter during VEND -> coin_reject, credit unchanged. Credit at 30 plus a dime -> reject, credit stays 30. Cancel plus quarter at credit 2 -> reject, REFUND pays one dime.
- Reset mid-CHANGE: credit 3 with change_ack low, then assert rst -> next cycle credit=0, ret_dime=0, state COLLECT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the soda vending controller.
//   state_t   : FSM state encoding (also exported on state_check)
//   *_V       : coin values in nickel units
//   PRICE_DEF / CREDIT_W_DEF : default price and credit register width
package vend_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'b000,
        ST_VEND    = 3'b001,
        ST_CHANGE  = 3'b010,
        ST_REFUND  = 3'b011
    } state_t;

    localparam int unsigned VALUE_W      = 3;
    localparam int unsigned NICKEL_V     = 1;
    localparam int unsigned DIME_V       = 2;
    localparam int unsigned QUARTER_V    = 5;
    localparam int unsigned PRICE_DEF    = 4;
    localparam int unsigned CREDIT_W_DEF = 5;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin strobe decoder.
//   nickel/dime/quarter : coin strobes
//   valid   : exactly one strobe high
//   illegal : more than one strobe high
//   value   : coin value in nickel units (0 unless valid)
module coin_decoder
    import vend_pkg::*;
(
    input  logic               nickel,
    input  logic               dime,
    input  logic               quarter,
    output logic               valid,
    output logic               illegal,
    output logic [VALUE_W-1:0] value
);

    logic [1:0] cnt;

    always_comb begin
        cnt     = 2'(nickel) + 2'(dime) + 2'(quarter);
        valid   = (cnt == 2'd1);
        illegal = (cnt > 2'd1);
        value   = '0;
        if (valid) begin
            if (nickel)    value = VALUE_W'(NICKEL_V);
            else if (dime) value = VALUE_W'(DIME_V);
            else           value = VALUE_W'(QUARTER_V);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: owns the credit register, handshakes a vend with the
// dispenser, pays change one coin at a time, and services cancel/refund.
//   clk, rst (sync, active-high)
//   nickel/dime/quarter : coin strobes;  cancel : refund request
//   vend_ack / change_ack : dispenser and coin-return acknowledges
//   credit : credit in nickel units;  vend_req : dispense request
//   ret_nickel / ret_dime : coin presented for return
//   coin_reject : one-cycle pulse for a coin rejected on the previous edge
//   state_check : current FSM state encoding
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE    = PRICE_DEF,
    parameter int unsigned CREDIT_W = CREDIT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic                ret_nickel,
    output logic                ret_dime,
    output logic                coin_reject,
    output logic [2:0]          state_check
);

    localparam int unsigned SUM_W      = CREDIT_W + 1;
    localparam int unsigned MAX_CREDIT = (1 << CREDIT_W) - 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic               coin_valid;
    logic               coin_illegal;
    logic [VALUE_W-1:0] coin_value;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [SUM_W-1:0]    sum;
    logic                reject_d;
    logic                payout_d;

    coin_decoder u_dec (
        .nickel  (nickel),
        .dime    (dime),
        .quarter (quarter),
        .valid   (coin_valid),
        .illegal (coin_illegal),
        .value   (coin_value)
    );

    // Next-state and next-credit logic
    always_comb begin
        state_d  = state_q;
        credit_d = credit;
        reject_d = 1'b0;
        // One extra bit so an overflowing deposit is visible before it wraps
        sum      = SUM_W'(credit) + SUM_W'(coin_value);
        case (state_q)
            ST_COLLECT: begin
                if (cancel && (credit != '0)) begin
                    state_d  = ST_REFUND;
                    reject_d = coin_valid | coin_illegal;
                end else begin
                    if (coin_illegal) begin
                        reject_d = 1'b1;
                    end else if (coin_valid) begin
                        if (sum <= SUM_W'(MAX_CREDIT)) credit_d = sum[CREDIT_W-1:0];
                        else                           reject_d = 1'b1;
                    end
                    if (credit_d >= PRICE_C) state_d = ST_VEND;
                end
            end
            ST_VEND: begin
                reject_d = coin_valid | coin_illegal;
                if (vend_ack) begin
                    credit_d = credit - PRICE_C;
                    state_d  = (credit_d == '0) ? ST_COLLECT : ST_CHANGE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                reject_d = coin_valid | coin_illegal;
                if (credit == '0) begin
                    state_d = ST_COLLECT;
                end else if (change_ack) begin
                    credit_d = (credit >= CREDIT_W'(2)) ? credit - CREDIT_W'(2)
                                                        : credit - CREDIT_W'(1);
                    if (credit_d == '0) state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d  = ST_COLLECT;
                credit_d = '0;
            end
        endcase
        payout_d = (state_d == ST_CHANGE) || (state_d == ST_REFUND);
    end

    // State, credit and output registers; outputs follow the next state/credit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            credit      <= '0;
            vend_req    <= 1'b0;
            ret_nickel  <= 1'b0;
            ret_dime    <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            vend_req    <= (state_d == ST_VEND);
            ret_dime    <= payout_d && (credit_d >= CREDIT_W'(2));
            ret_nickel  <= payout_d && (credit_d == CREDIT_W'(1));
            coin_reject <= reject_d;
        end
    end

    assign state_check = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: a per-cycle vector table (PRICE=4)
// scored through an expectation queue, plus a hand-written overflow sequence
// on a second instance with PRICE=31.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst, nickel, dime, quarter, cancel, vend_ack, change_ack;
    logic [4:0] credit;
    logic       vend_req, ret_nickel, ret_dime, coin_reject;
    logic [2:0] state_check;

    logic       rst2, nickel2, dime2, quarter2, cancel2, vend_ack2, change_ack2;
    logic [4:0] credit2;
    logic       vend_req2, ret_nickel2, ret_dime2, coin_reject2;
    logic [2:0] state_check2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vend_controller #(.PRICE(4), .CREDIT_W(5)) dut (
        .clk(clk), .rst(rst), .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .vend_ack(vend_ack), .change_ack(change_ack),
        .credit(credit), .vend_req(vend_req), .ret_nickel(ret_nickel),
        .ret_dime(ret_dime), .coin_reject(coin_reject), .state_check(state_check)
    );

    vend_controller #(.PRICE(31), .CREDIT_W(5)) dut2 (
        .clk(clk), .rst(rst2), .nickel(nickel2), .dime(dime2), .quarter(quarter2),
        .cancel(cancel2), .vend_ack(vend_ack2), .change_ack(change_ack2),
        .credit(credit2), .vend_req(vend_req2), .ret_nickel(ret_nickel2),
        .ret_dime(ret_dime2), .coin_reject(coin_reject2), .state_check(state_check2)
    );

    // inputs packed {rst,nickel,dime,quarter,cancel,vend_ack,change_ack}
    // outputs packed {credit[4:0],vend_req,ret_nickel,ret_dime,coin_reject,state[2:0]}
    typedef struct {
        logic [6:0]  in;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [11:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic logic [11:0] o(int cr, bit vr, bit rn, bit rd, bit rj, int st);
        return {5'(cr), vr, rn, rd, rj, 3'(st)};
    endfunction

    task automatic add(logic [6:0] in, logic [11:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Scoreboard: pop and compare one expectation per clock
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_t e;
            logic [11:0] act;
            e   = sb.pop_front();
            act = {credit, vend_req, ret_nickel, ret_dime, coin_reject, state_check};
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL vec%0d: got cr=%0d vr=%b rn=%b rd=%b rj=%b st=%0d, want cr=%0d vr=%b rn=%b rd=%b rj=%b st=%0d",
                         e.idx, act[11:7], act[6], act[5], act[4], act[3], act[2:0],
                         e.exp[11:7], e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
            end
        end
    end

    task automatic step2(string nm, logic [6:0] in, logic [11:0] exp);
        logic [11:0] act;
        @(negedge clk);
        {rst2, nickel2, dime2, quarter2, cancel2, vend_ack2, change_ack2} = in;
        @(posedge clk);
        #2;
        act = {credit2, vend_req2, ret_nickel2, ret_dime2, coin_reject2, state_check2};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got cr=%0d vr=%b rj=%b st=%0d, want cr=%0d vr=%b rj=%b st=%0d",
                     nm, act[11:7], act[6], act[3], act[2:0],
                     exp[11:7], exp[6], exp[3], exp[2:0]);
        end
    endtask

    initial begin
        {rst, nickel, dime, quarter, cancel, vend_ack, change_ack} = 7'b1000000;
        {rst2, nickel2, dime2, quarter2, cancel2, vend_ack2, change_ack2} = 7'b1000000;

        // Reset with coins toggling
        add(7'b1100000, o(0,0,0,0,0,0));
        add(7'b1011000, o(0,0,0,0,0,0));
        // Exact price: dime, dime, vend_ack tied high
        add(7'b0010010, o(2,0,0,0,0,0));
        add(7'b0010010, o(4,1,0,0,0,1));
        add(7'b0000010, o(0,0,0,0,0,0));
        add(7'b0000000, o(0,0,0,0,0,0));
        // Overpay: quarter, acks held off for 3 cycles each
        add(7'b0001000, o(5,1,0,0,0,1));
        add(7'b0000000, o(5,1,0,0,0,1));
        add(7'b0000000, o(5,1,0,0,0,1));
        add(7'b0000010, o(1,0,1,0,0,2));
        add(7'b0000000, o(1,0,1,0,0,2));
        add(7'b0000000, o(1,0,1,0,0,2));
        add(7'b0000001, o(0,0,0,0,0,0));
        // Refund: nickel, dime, cancel -> dime then nickel
        add(7'b0100000, o(1,0,0,0,0,0));
        add(7'b0010000, o(3,0,0,0,0,0));
        add(7'b0000100, o(3,0,0,1,0,3));
        add(7'b0000001, o(1,0,1,0,0,3));
        add(7'b0000001, o(0,0,0,0,0,0));
        // Two strobes at once
        add(7'b0110000, o(0,0,0,0,1,0));
        add(7'b0000000, o(0,0,0,0,0,0));
        // Quarter during VEND
        add(7'b0001000, o(5,1,0,0,0,1));
        add(7'b0001000, o(5,1,0,0,1,1));
        add(7'b0000010, o(1,0,1,0,0,2));
        add(7'b0000001, o(0,0,0,0,0,0));
        // Cancel plus quarter at credit 2
        add(7'b0010000, o(2,0,0,0,0,0));
        add(7'b0001100, o(2,0,0,1,1,3));
        add(7'b0000001, o(0,0,0,0,0,0));
        // Cancel at credit 0 is ignored; coin still taken
        add(7'b0100100, o(1,0,0,0,0,0));
        add(7'b0000100, o(1,0,1,0,0,3));
        add(7'b0000001, o(0,0,0,0,0,0));
        // Reset mid-CHANGE with credit 3
        add(7'b0010000, o(2,0,0,0,0,0));
        add(7'b0001000, o(7,1,0,0,0,1));
        add(7'b0000010, o(3,0,0,1,0,2));
        add(7'b0000000, o(3,0,0,1,0,2));
        add(7'b1000000, o(0,0,0,0,0,0));
        add(7'b0000000, o(0,0,0,0,0,0));
        // Stray acks in COLLECT ignored; triple strobe rejected
        add(7'b0100011, o(1,0,0,0,0,0));
        add(7'b0111000, o(1,0,0,0,1,0));
        add(7'b1000000, o(0,0,0,0,0,0));

        foreach (vecs[i]) begin
            sb_t e;
            @(negedge clk);
            {rst, nickel, dime, quarter, cancel, vend_ack, change_ack} = vecs[i].in;
            e.idx = i;
            e.exp = vecs[i].exp;
            sb.push_back(e);
        end
        @(negedge clk);
        {rst, nickel, dime, quarter, cancel, vend_ack, change_ack} = 7'b0000000;
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        // Overflow at credit 30 on the PRICE=31 instance
        step2("p31_reset", 7'b1000000, o(0,0,0,0,0,0));
        for (int k = 1; k <= 6; k++)
            step2("p31_quarter", 7'b0001000, o(5*k,0,0,0,0,0));
        step2("p31_dime_over", 7'b0010000, o(30,0,0,0,1,0));
        step2("p31_quarter_over", 7'b0001000, o(30,0,0,0,1,0));
        step2("p31_nickel_fill", 7'b0100000, o(31,1,0,0,0,1));
        step2("p31_vend", 7'b0000010, o(0,0,0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
